// File: rtl/bsg_cycle_interval_meter_pkg.sv
// Shared types for the cycle interval meter.
// Holds the FSM state encoding used by the top and by anything that observes it.
// No logic lives here.
package bsg_cycle_interval_meter_pkg;

    typedef enum logic [1:0] {
        e_idle = 2'd0,
        e_run  = 2'd1,
        e_done = 2'd2
    } bsg_cim_state_e;

endpackage

// File: rtl/bsg_dff_reset_en.sv
// Enabled register with synchronous active-high reset to a constant.
// Latency: one cycle from en_i to data_o.
// Backpressure: none; holds its value while en_i is low.
module bsg_dff_reset_en #(
    parameter int                 width_p     = 1,
    parameter logic [width_p-1:0] reset_val_p = '0
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               en_i,
    input  logic [width_p-1:0] data_i,
    output logic [width_p-1:0] data_o
);

    logic [width_p-1:0] data_q;
    logic [width_p-1:0] data_d;

    always_comb begin
        data_d = data_q;
        if (en_i) begin
            data_d = data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            data_q <= reset_val_p;
        end else begin
            data_q <= data_d;
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/bsg_cycle_interval_meter.sv
// Measures cycles between start_i and stop_i from a shared free-running counter.
// Latency: busy_o one cycle after start_i; v_o/data_o one cycle after stop_i.
// Backpressure: result held in DONE until yumi_i; events arriving meanwhile are dropped.
module bsg_cycle_interval_meter
    import bsg_cycle_interval_meter_pkg::*;
#(
    parameter int width_p = 32
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic [width_p-1:0] ctr_i,
    input  logic               start_i,
    input  logic               stop_i,
    output logic               busy_o,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i
);

    bsg_cim_state_e     state_q;
    bsg_cim_state_e     state_d;
    logic               start_en;
    logic               data_en;
    logic [width_p-1:0] start_r;
    logic [width_p-1:0] data_r;
    logic [width_p-1:0] elapsed;

    // Modular subtract: counter wrap inside the interval cancels out.
    assign elapsed = ctr_i - start_r;

    always_comb begin
        state_d  = state_q;
        start_en = 1'b0;
        data_en  = 1'b0;
        unique case (state_q)
            e_idle: begin
                if (start_i) begin
                    start_en = 1'b1;
                    state_d  = e_run;
                end
            end
            e_run: begin
                if (stop_i) begin
                    data_en = 1'b1;
                    state_d = e_done;
                end else if (start_i) begin
                    start_en = 1'b1;
                end
            end
            e_done: begin
                if (yumi_i) begin
                    if (start_i) begin
                        start_en = 1'b1;
                        state_d  = e_run;
                    end else begin
                        state_d  = e_idle;
                    end
                end
            end
            default: state_d = e_idle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= e_idle;
        end else begin
            state_q <= state_d;
        end
    end

    bsg_dff_reset_en #(
        .width_p     (width_p),
        .reset_val_p ('0)
    ) start_reg (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .en_i    (start_en),
        .data_i  (ctr_i),
        .data_o  (start_r)
    );

    bsg_dff_reset_en #(
        .width_p     (width_p),
        .reset_val_p ('0)
    ) data_reg (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .en_i    (data_en),
        .data_i  (elapsed),
        .data_o  (data_r)
    );

    assign busy_o = (state_q == e_run);
    assign v_o    = (state_q == e_done);
    assign data_o = data_r;

    yumi_needs_valid: assert property (@(posedge clk_i) disable iff (reset_i) yumi_i |-> v_o)
        else $error("yumi_i asserted without v_o");

endmodule

// File: tb/tb_bsg_cycle_interval_meter.sv
// Scoreboard bench for bsg_cycle_interval_meter: expected intervals queued at stop, checked at consume.
module tb_bsg_cycle_interval_meter;

    localparam int width_p = 32;

    logic               clk_i;
    logic               reset_i;
    logic [width_p-1:0] ctr_i;
    logic               start_i;
    logic               stop_i;
    logic               busy_o;
    logic               v_o;
    logic [width_p-1:0] data_o;
    logic               yumi_i;

    int err_cnt;
    int chk_cnt;
    logic [width_p-1:0] exp_q[$];
    logic [width_p-1:0] cur_ctr;
    logic [width_p-1:0] held;

    bsg_cycle_interval_meter #(.width_p(width_p)) dut (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .ctr_i   (ctr_i),
        .start_i (start_i),
        .stop_i  (stop_i),
        .busy_o  (busy_o),
        .v_o     (v_o),
        .data_o  (data_o),
        .yumi_i  (yumi_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk_eq(input string tag, input logic [width_p-1:0] got,
                          input logic [width_p-1:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock with the given inputs; outputs sampled 1ns after the edge.
    task automatic drive(input logic st, input logic sp, input logic ym,
                         input logic [width_p-1:0] c);
        start_i = st;
        stop_i  = sp;
        yumi_i  = ym;
        ctr_i   = c;
        cur_ctr = c;
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, cur_ctr + 1);
    endtask

    // Wait for a result, compare against the scoreboard head, then take it.
    task automatic consume(input string tag);
        int n;
        n = 0;
        while (v_o !== 1'b1 && n < 8) begin
            idle();
            n++;
        end
        if (v_o !== 1'b1) begin
            chk_eq({tag, "_timeout"}, {{(width_p-1){1'b0}}, v_o}, 1);
        end else if (exp_q.size() == 0) begin
            chk_eq({tag, "_unexpected"}, data_o, '1);
        end else begin
            chk_eq({tag, "_data"}, data_o, exp_q.pop_front());
            drive(1'b0, 1'b0, 1'b1, cur_ctr + 1);
            chk_eq({tag, "_v_after_yumi"}, {{(width_p-1){1'b0}}, v_o}, 0);
            chk_eq({tag, "_busy_after_yumi"}, {{(width_p-1){1'b0}}, busy_o}, 0);
            yumi_i = 1'b0;
        end
    endtask

    initial begin
        err_cnt = 0;
        chk_cnt = 0;
        start_i = 1'b0;
        stop_i  = 1'b0;
        yumi_i  = 1'b0;
        ctr_i   = '0;
        cur_ctr = '0;
        reset_i = 1'b1;
        idle();
        idle();
        chk_eq("rst_busy", {31'b0, busy_o}, 0);
        chk_eq("rst_v", {31'b0, v_o}, 0);
        chk_eq("rst_data", data_o, 0);
        reset_i = 1'b0;
        idle();

        // Basic interval
        drive(1'b1, 1'b0, 1'b0, 100);
        chk_eq("basic_busy", {31'b0, busy_o}, 1);
        exp_q.push_back(37);
        drive(1'b0, 1'b1, 1'b0, 137);
        chk_eq("basic_v", {31'b0, v_o}, 1);
        chk_eq("basic_busy_low", {31'b0, busy_o}, 0);
        for (int i = 0; i < 3; i++) begin
            idle();
            chk_eq("basic_hold", data_o, 37);
        end
        consume("basic");

        // Counter wrap
        drive(1'b1, 1'b0, 1'b0, 32'hFFFF_FFF0);
        exp_q.push_back(32'h20);
        drive(1'b0, 1'b1, 1'b0, 32'h0000_0010);
        consume("wrap");

        // Simultaneous start+stop in IDLE then in RUN
        drive(1'b1, 1'b1, 1'b0, 5);
        chk_eq("sim_idle_busy", {31'b0, busy_o}, 1);
        chk_eq("sim_idle_v", {31'b0, v_o}, 0);
        idle();
        exp_q.push_back(4);
        drive(1'b1, 1'b1, 1'b0, 9);
        chk_eq("sim_run_v", {31'b0, v_o}, 1);
        consume("sim_run");

        // Restart in RUN, then start+yumi back-to-back
        drive(1'b1, 1'b0, 1'b0, 40);
        drive(1'b1, 1'b0, 1'b0, 50);
        chk_eq("restart_busy", {31'b0, busy_o}, 1);
        exp_q.push_back(10);
        drive(1'b0, 1'b1, 1'b0, 60);
        chk_eq("restart_v", {31'b0, v_o}, 1);
        chk_eq("restart_data", data_o, exp_q.pop_front());
        drive(1'b1, 1'b0, 1'b1, 70);
        chk_eq("b2b_v", {31'b0, v_o}, 0);
        chk_eq("b2b_busy", {31'b0, busy_o}, 1);
        exp_q.push_back(1);
        drive(1'b0, 1'b1, 1'b0, 71);
        consume("b2b");

        // Backpressure with ignored events
        drive(1'b1, 1'b0, 1'b0, 200);
        exp_q.push_back(100);
        drive(1'b0, 1'b1, 1'b0, 300);
        for (int i = 0; i < 20; i++) begin
            drive(i[0], i[1], 1'b0, cur_ctr + 1);
            chk_eq("bp_v", {31'b0, v_o}, 1);
            chk_eq("bp_data", data_o, 100);
        end
        consume("bp");

        // Reset while RUN
        drive(1'b1, 1'b0, 1'b0, 400);
        chk_eq("rst_run_pre_busy", {31'b0, busy_o}, 1);
        reset_i = 1'b1;
        idle();
        chk_eq("rst_run_busy", {31'b0, busy_o}, 0);
        chk_eq("rst_run_v", {31'b0, v_o}, 0);
        chk_eq("rst_run_data", data_o, 0);
        reset_i = 1'b0;
        drive(1'b0, 1'b1, 1'b0, cur_ctr + 1);
        chk_eq("rst_run_no_result", {31'b0, v_o}, 0);

        // Reset while DONE: result must be discarded
        drive(1'b1, 1'b0, 1'b0, 500);
        drive(1'b0, 1'b1, 1'b0, 510);
        chk_eq("rst_done_pre_v", {31'b0, v_o}, 1);
        reset_i = 1'b1;
        idle();
        chk_eq("rst_done_busy", {31'b0, busy_o}, 0);
        chk_eq("rst_done_v", {31'b0, v_o}, 0);
        chk_eq("rst_done_data", data_o, 0);
        reset_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            idle();
            chk_eq("rst_done_stale", {31'b0, v_o}, 0);
        end
        held = exp_q.size();
        chk_eq("sb_empty", held, 0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
